// File: rtl/tile_command_issuer.sv
// rtl/tile_command_issuer.sv - tile opcode issuer: spawn, gravity and button commands over valid/ready

package tile_pkg;

    // Opcodes understood by the matrix controller
    typedef enum logic [2:0] {
        eNOP       = 3'd0,
        eNewTile   = 3'd1,
        eMoveDown  = 3'd2,
        eRotate    = 3'd3,
        eMoveLeft  = 3'd4,
        eMoveRight = 3'd5
    } tile_opcode_e;

endpackage

module tile_command_issuer
    import tile_pkg::*;
#(
    parameter int         gravity_period_p = 1000,
    parameter int         drop_shift_p     = 3,
    parameter logic [7:0] lfsr_seed_p      = 8'hA5
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic         btn_left_i,
    input  logic         btn_right_i,
    input  logic         btn_rotate_i,
    input  logic         btn_drop_i,
    input  logic         tile_landed_i,
    input  logic         game_over_i,
    output tile_opcode_e opcode_o,
    output logic [7:0]   opcode_op_o,
    output logic         op_v_o,
    input  logic         ready_i,
    output logic [15:0]  tile_count_o,
    output logic         game_over_o
);

    // Fast-drop period, never allowed to collapse below one cycle
    localparam int drop_period_lp =
        ((gravity_period_p >> drop_shift_p) > 0) ? (gravity_period_p >> drop_shift_p) : 1;
    localparam int cnt_w_lp = $clog2(gravity_period_p);
    localparam logic [cnt_w_lp-1:0] norm_reload_lp = cnt_w_lp'(gravity_period_p - 1);
    localparam logic [cnt_w_lp-1:0] drop_reload_lp = cnt_w_lp'(drop_period_lp - 1);

    typedef enum logic [2:0] {
        eIdle  = 3'd0,
        eSpawn = 3'd1,
        eRun   = 3'd2,
        eIssue = 3'd3,
        eOver  = 3'd4
    } state_e;

    state_e                state;
    state_e                next_state;

    logic [7:0]            lfsr;
    logic                  lfsr_fb;
    logic [2:0]            tile_type;

    tile_opcode_e          opcode_q;
    logic [7:0]            operand_q;
    logic [15:0]           tile_count_q;

    logic                  prev_left;
    logic                  prev_right;
    logic                  prev_rotate;
    logic                  prev_drop;

    logic                  pend_new;
    logic                  pend_down;
    logic                  pend_rot;
    logic                  pend_left;
    logic                  pend_right;

    logic                  set_new;
    logic                  set_down;
    logic                  set_rot;
    logic                  set_left;
    logic                  set_right;

    logic [cnt_w_lp-1:0]   grav_cnt;
    logic [cnt_w_lp-1:0]   grav_reload;
    logic                  grav_run;
    logic                  grav_expire;

    logic                  active;
    logic                  op_v;
    logic                  xfer;
    logic                  xfer_new;
    logic                  any_pend;
    logic                  spawn_entry;
    tile_opcode_e          sel_op;

    // Handshake and request qualification
    assign op_v        = (state == eIssue);
    assign xfer        = op_v && ready_i;
    assign xfer_new    = xfer && (opcode_q == eNewTile);
    assign active      = (state != eIdle);
    assign any_pend    = pend_down | pend_rot | pend_left | pend_right;
    assign spawn_entry = (next_state == eSpawn) && (state != eSpawn);

    // Button edges count only once a game is running
    assign set_rot   = active && btn_rotate_i && !prev_rotate;
    assign set_left  = active && btn_left_i   && !prev_left;
    assign set_right = active && btn_right_i  && !prev_right;
    assign set_new   = active && tile_landed_i;
    assign set_down  = (active && btn_drop_i && !prev_drop) || grav_expire;

    // Gravity runs only while the tile is in play
    assign grav_run    = (state == eRun) || (state == eIssue);
    assign grav_expire = grav_run && (grav_cnt == '0);
    assign grav_reload = btn_drop_i ? drop_reload_lp : norm_reload_lp;

    // Shape choice: 7 folds onto 0 so the seven tile types stay in range
    assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign tile_type = (lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0];

    // LFSR free-runs in every state so the shape depends on timing
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            lfsr <= lfsr_seed_p;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end

    // Previous button levels for rising-edge detection
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            prev_left   <= 1'b0;
            prev_right  <= 1'b0;
            prev_rotate <= 1'b0;
            prev_drop   <= 1'b0;
        end else begin
            prev_left   <= btn_left_i;
            prev_right  <= btn_right_i;
            prev_rotate <= btn_rotate_i;
            prev_drop   <= btn_drop_i;
        end
    end

    // Pending requests: a set in the same cycle as the clearing transfer wins
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pend_new   <= 1'b0;
            pend_down  <= 1'b0;
            pend_rot   <= 1'b0;
            pend_left  <= 1'b0;
            pend_right <= 1'b0;
        end else begin
            pend_new   <= (pend_new   && !(xfer && (opcode_q == eNewTile)))   || set_new;
            pend_down  <= (pend_down  && !(xfer && (opcode_q == eMoveDown)))  || set_down;
            pend_rot   <= (pend_rot   && !(xfer && (opcode_q == eRotate)))    || set_rot;
            pend_left  <= (pend_left  && !(xfer && (opcode_q == eMoveLeft)))  || set_left;
            pend_right <= (pend_right && !(xfer && (opcode_q == eMoveRight))) || set_right;
        end
    end

    // Gravity timer; a freshly spawned tile gets a full period
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            grav_cnt <= norm_reload_lp;
        end else if (xfer_new) begin
            grav_cnt <= grav_reload;
        end else if (grav_run) begin
            if (grav_cnt == '0) begin
                grav_cnt <= grav_reload;
            end else begin
                grav_cnt <= grav_cnt - 1'b1;
            end
        end
    end

    // Accepted new-tile counter
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tile_count_q <= 16'd0;
        end else if (xfer_new) begin
            tile_count_q <= tile_count_q + 16'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= eIdle;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state; game over from a live game overrides everything
    always_comb begin
        next_state = state;
        case (state)
            eIdle: begin
                if (start_i) begin
                    next_state = eSpawn;
                end
            end
            eSpawn: begin
                next_state = eIssue;
            end
            eRun: begin
                if (pend_new) begin
                    next_state = eSpawn;
                end else if (any_pend) begin
                    next_state = eIssue;
                end
            end
            eIssue: begin
                if (xfer) begin
                    next_state = eRun;
                end
            end
            eOver: begin
                next_state = eOver;
            end
            default: begin
                next_state = eIdle;
            end
        endcase
        if ((state != eIdle) && game_over_i) begin
            next_state = eOver;
        end
    end

    // Highest-priority movement request (new tile handled via eSpawn)
    always_comb begin
        sel_op = eNOP;
        if (pend_down) begin
            sel_op = eMoveDown;
        end else if (pend_rot) begin
            sel_op = eRotate;
        end else if (pend_left) begin
            sel_op = eMoveLeft;
        end else if (pend_right) begin
            sel_op = eMoveRight;
        end
    end

    // Command register: loaded ahead of valid, frozen until transfer or abort
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            opcode_q  <= eNOP;
            operand_q <= 8'd0;
        end else if (next_state == eOver) begin
            opcode_q  <= eNOP;
            operand_q <= 8'd0;
        end else if (spawn_entry) begin
            opcode_q  <= eNewTile;
            operand_q <= {5'd0, tile_type};
        end else if ((state == eRun) && (next_state == eIssue)) begin
            opcode_q  <= sel_op;
            operand_q <= 8'd0;
        end else if (xfer) begin
            opcode_q  <= eNOP;
            operand_q <= 8'd0;
        end
    end

    // FSM outputs
    always_comb begin
        op_v_o       = op_v;
        game_over_o  = (state == eOver);
        opcode_o     = opcode_q;
        opcode_op_o  = operand_q;
        tile_count_o = tile_count_q;
    end

endmodule
